// File: rtl/psum_accum_ctrl.sv
// Partial-sum sequencer around the accumulator: owns PSUM_Q, drives flush/bias-select
// across K-tiles, requantizes the final tile and queues it in a 2-entry output buffer.
module psum_accum_ctrl #(
    parameter int N_ACC   = 32,
    parameter int N_OUT   = 8,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 10
) (
    input  logic               i_CLK,
    input  logic               i_RSTn,
    input  logic               i_Start,
    input  logic [CNT_W-1:0]   i_Num_Tiles,
    input  logic [CNT_W-1:0]   i_Num_Outs,
    input  logic [SHIFT_W-1:0] i_Shift,
    input  logic               i_Relu,
    input  logic               i_Core_Vld,
    output logic               o_Core_Rdy,
    input  logic [N_ACC-1:0]   i_PSUM_D,
    output logic [N_ACC-1:0]   o_PSUM_Q,
    output logic               o_Flush,
    output logic               o_Sel_Bias_BUF,
    output logic               o_Out_Vld,
    input  logic               i_Out_Rdy,
    output logic [N_OUT-1:0]   o_Out_Data,
    output logic               o_Busy,
    output logic               o_Done,
    output logic [1:0]         o_Dbg_State
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; ready never depends combinationally on the same cycle's valid.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic signed [N_ACC:0] RQ_ONE  = (N_ACC+1)'(1);
    localparam logic signed [N_ACC:0] SAT_MAX = (N_ACC+1)'((1 << (N_OUT-1)) - 1);
    localparam logic signed [N_ACC:0] SAT_MIN = ~SAT_MAX;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_tiles_q, num_tiles_d;
    logic [CNT_W-1:0]   num_outs_q, num_outs_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               relu_q, relu_d;
    logic [CNT_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [N_ACC-1:0]   psum_q, psum_d;
    logic [N_OUT-1:0]   buf_q [2];
    logic [N_OUT-1:0]   buf_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         buf_cnt_q, buf_cnt_d;

    logic               core_rdy, accept, last_tile, push, pop, done;
    logic signed [N_ACC:0] rq_x, rq_rnd, rq_y;
    logic [N_OUT-1:0]   rq_out;

    // Requantization is one bit wider than the accumulator so the rounding add cannot wrap.
    always_comb begin
        rq_x   = $signed({i_PSUM_D[N_ACC-1], i_PSUM_D});
        rq_rnd = '0;
        if (shift_q != '0) begin
            rq_rnd = RQ_ONE << (shift_q - SHIFT_W'(1));
        end
        rq_y = (rq_x + rq_rnd) >>> shift_q;
        if (relu_q && rq_y[N_ACC]) begin
            rq_y = '0;
        end
        if (rq_y > SAT_MAX) begin
            rq_out = SAT_MAX[N_OUT-1:0];
        end else if (rq_y < SAT_MIN) begin
            rq_out = SAT_MIN[N_OUT-1:0];
        end else begin
            rq_out = rq_y[N_OUT-1:0];
        end
    end

    always_comb begin
        core_rdy  = (state_q == S_ACC) && (buf_cnt_q != 2'd2);
        accept    = core_rdy && i_Core_Vld;
        last_tile = (tile_cnt_q == num_tiles_q - CNT_W'(1));
        push      = accept && last_tile;
        pop       = (buf_cnt_q != 2'd0) && i_Out_Rdy;
        done      = 1'b0;

        state_d     = state_q;
        num_tiles_d = num_tiles_q;
        num_outs_d  = num_outs_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        tile_cnt_d  = tile_cnt_q;
        out_cnt_d   = out_cnt_q;
        psum_d      = psum_q;

        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    num_tiles_d = (i_Num_Tiles == '0) ? CNT_W'(1) : i_Num_Tiles;
                    num_outs_d  = (i_Num_Outs == '0) ? CNT_W'(1) : i_Num_Outs;
                    shift_d     = i_Shift;
                    relu_d      = i_Relu;
                    tile_cnt_d  = '0;
                    out_cnt_d   = '0;
                    state_d     = S_ACC;
                end
            end
            S_ACC: begin
                if (accept) begin
                    psum_d = i_PSUM_D;
                    if (last_tile) begin
                        tile_cnt_d = '0;
                        out_cnt_d  = out_cnt_q + CNT_W'(1);
                        if (out_cnt_q == num_outs_q - CNT_W'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        tile_cnt_d = tile_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (buf_cnt_q == 2'd0) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        buf_d     = buf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        buf_cnt_d = buf_cnt_q;
        if (push) begin
            buf_d[wr_ptr_q] = rq_out;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
            2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
            default: buf_cnt_d = buf_cnt_q;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q     <= S_IDLE;
            num_tiles_q <= '0;
            num_outs_q  <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            tile_cnt_q  <= '0;
            out_cnt_q   <= '0;
            psum_q      <= '0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            buf_cnt_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            num_tiles_q <= num_tiles_d;
            num_outs_q  <= num_outs_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            tile_cnt_q  <= tile_cnt_d;
            out_cnt_q   <= out_cnt_d;
            psum_q      <= psum_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            buf_cnt_q   <= buf_cnt_d;
        end
    end

    assign o_Core_Rdy     = core_rdy;
    assign o_PSUM_Q       = psum_q;
    assign o_Flush        = (tile_cnt_q == '0);
    assign o_Sel_Bias_BUF = last_tile;
    assign o_Out_Vld      = (buf_cnt_q != 2'd0);
    assign o_Out_Data     = buf_q[rd_ptr_q];
    assign o_Busy         = (state_q != S_IDLE);
    assign o_Done         = done;
    assign o_Dbg_State    = state_q;

endmodule
